// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the eFPGA ccff scan-chain loader.
// Other files and the readback checker import this package.
package ccff_chain_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Valid bits carried by the final bitstream word of the chain.
    function automatic int last_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream write / readback handshake bundle of the ccff loader.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/ccff_chain_loader_word_serializer.sv
// Write side of the ccff loader: shift register, one-word hold buffer and
// chain bit counter feeding ccff_head one bit per shift.
module ccff_chain_loader_word_serializer
    import ccff_chain_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              shift,
    output logic              has_bit,
    output logic              head_bit,
    output logic [CNT_W-1:0]  bit_cnt
);
    localparam int WC_W = $clog2(WORD_W + 1);
    localparam logic [WC_W-1:0]  FULL_BITS  = WC_W'(WORD_W);
    localparam logic [WC_W-1:0]  FINAL_BITS = WC_W'(last_bits(CHAIN_LEN, WORD_W));
    localparam logic [CNT_W-1:0] CHAIN_END  = CNT_W'(CHAIN_LEN);

    logic [WORD_W-1:0] sreg_r, hold_r;
    logic [WC_W-1:0]   sreg_cnt_r, hold_cnt_r, word_bits_s;
    logic              hold_full_r, accept_s, sreg_drain_s;
    logic [CNT_W-1:0]  fetch_cnt_r, bit_cnt_r;
    logic [31:0]       remain_s;

    // Handshake and refill decisions for the current cycle.
    always_comb begin
        remain_s     = 32'(CHAIN_LEN) - 32'(fetch_cnt_r);
        word_bits_s  = (remain_s <= 32'(WORD_W)) ? FINAL_BITS : FULL_BITS;
        wr_ready     = load_en && !hold_full_r && (fetch_cnt_r != CHAIN_END);
        accept_s     = wr_valid && wr_ready;
        sreg_drain_s = (sreg_cnt_r == {WC_W{1'b0}}) ||
                       (shift && (sreg_cnt_r == WC_W'(1)));
        has_bit      = (sreg_cnt_r != {WC_W{1'b0}});
        head_bit     = sreg_r[0];
        bit_cnt      = bit_cnt_r;
    end

    // Shift/refill state; later assignments override the plain shift on refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r      <= {WORD_W{1'b0}};
            hold_r      <= {WORD_W{1'b0}};
            sreg_cnt_r  <= {WC_W{1'b0}};
            hold_cnt_r  <= {WC_W{1'b0}};
            hold_full_r <= 1'b0;
            fetch_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
        end else if (clr) begin
            sreg_r      <= {WORD_W{1'b0}};
            hold_r      <= {WORD_W{1'b0}};
            sreg_cnt_r  <= {WC_W{1'b0}};
            hold_cnt_r  <= {WC_W{1'b0}};
            hold_full_r <= 1'b0;
            fetch_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (shift) begin
                sreg_r     <= sreg_r >> 1;
                sreg_cnt_r <= sreg_cnt_r - WC_W'(1);
                bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
            end
            if (sreg_drain_s && hold_full_r) begin
                sreg_r      <= hold_r;
                sreg_cnt_r  <= hold_cnt_r;
                hold_full_r <= 1'b0;
            end else if (accept_s && sreg_drain_s) begin
                sreg_r     <= wr_data;
                sreg_cnt_r <= word_bits_s;
            end else if (accept_s) begin
                hold_r      <= wr_data;
                hold_cnt_r  <= word_bits_s;
                hold_full_r <= 1'b1;
            end
            if (accept_s) begin
                fetch_cnt_r <= fetch_cnt_r + CNT_W'(word_bits_s);
            end
        end
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// eFPGA ccff scan-chain loader: serializes bitstream words onto ccff_head while
// deserializing ccff_tail into readback words, under a 4-state sequencer.
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic                prog_clk,
    input  logic                prog_rst_n,
    input  logic                start,
    input  logic                abort,
    ccff_chain_loader_if.slave  host,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                shift_en,
    output logic                busy,
    output logic                done
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int RC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
    localparam logic [RC_W-1:0]  RD_TOP    = RC_W'(WORD_W - 1);

    state_t            state_r, state_n_s;
    logic [CNT_W-1:0]  bit_cnt_s;
    logic              ser_clr_s, has_bit_s, head_bit_s, wr_ready_s;
    logic              last_bit_s, word_done_s, rd_stall_s, shift_s;
    logic [WORD_W-1:0] rd_word_s, rd_shift_r, rd_data_r;
    logic [RC_W-1:0]   rd_cnt_r;
    logic              rd_valid_r;

    ccff_chain_loader_word_serializer #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .clr      (ser_clr_s),
        .load_en  (state_r == ST_LOAD),
        .wr_data  (host.wr_data),
        .wr_valid (host.wr_valid),
        .wr_ready (wr_ready_s),
        .shift    (shift_s),
        .has_bit  (has_bit_s),
        .head_bit (head_bit_s),
        .bit_cnt  (bit_cnt_s)
    );

    // Shift qualification: stall only when this bit would complete a readback word
    // that cannot be handed over yet; abort always wins.
    always_comb begin
        last_bit_s  = (bit_cnt_s == LAST_IDX);
        word_done_s = (rd_cnt_r == RD_TOP) || last_bit_s;
        rd_stall_s  = word_done_s && rd_valid_r && !host.rd_ready;
        shift_s     = (state_r == ST_LOAD) && has_bit_s && !rd_stall_s &&
                      (bit_cnt_s != CHAIN_END) && !abort;
        rd_word_s   = rd_shift_r | ({{(WORD_W-1){1'b0}}, ccff_tail} << rd_cnt_r);
        ser_clr_s   = abort || (state_r == ST_IDLE) || (state_r == ST_DONE);
    end

    // Next-state logic of the load sequencer.
    always_comb begin
        state_n_s = state_r;
        if (abort) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_n_s = start ? ST_LOAD : ST_IDLE;
                ST_LOAD:  state_n_s = (shift_s && last_bit_s) ? ST_DRAIN : ST_LOAD;
                ST_DRAIN: state_n_s = (rd_valid_r && host.rd_ready) ? ST_DONE : ST_DRAIN;
                ST_DONE:  state_n_s = ST_IDLE;
                default:  state_n_s = ST_IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Readback deserializer; partial words are cleared between loads so padding is zero.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            rd_shift_r <= {WORD_W{1'b0}};
            rd_data_r  <= {WORD_W{1'b0}};
            rd_cnt_r   <= {RC_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (abort || (state_r == ST_IDLE)) begin
            rd_shift_r <= {WORD_W{1'b0}};
            rd_data_r  <= {WORD_W{1'b0}};
            rd_cnt_r   <= {RC_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            if (host.rd_ready) begin
                rd_valid_r <= 1'b0;
            end
            if (shift_s) begin
                if (word_done_s) begin
                    rd_data_r  <= rd_word_s;
                    rd_valid_r <= 1'b1;
                    rd_shift_r <= {WORD_W{1'b0}};
                    rd_cnt_r   <= {RC_W{1'b0}};
                end else begin
                    rd_shift_r <= rd_word_s;
                    rd_cnt_r   <= rd_cnt_r + RC_W'(1);
                end
            end
        end
    end

    assign shift_en      = shift_s;
    assign ccff_head     = shift_s & head_bit_s;
    assign busy          = (state_r != ST_IDLE);
    assign done          = (state_r == ST_DONE);
    assign host.wr_ready = wr_ready_s;
    assign host.rd_data  = rd_data_r;
    assign host.rd_valid = rd_valid_r;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with a 40-bit chain model clocked on shift_en.
module tb_ccff_chain_loader;
    localparam logic [31:0] W0 = 32'h12345678;
    localparam logic [31:0] W1 = 32'h000000CD;
    localparam logic [31:0] W2 = 32'hDEADBEEF;

    logic prog_clk = 1'b0;
    logic prog_rst_n, start, abort, ccff_head, ccff_tail, shift_en, busy, done;
    logic chain_load;
    logic [39:0] chain, chain_preset;

    int n_checks = 0;
    int n_fail = 0;

    int r_shift, r_first, r_last, r_done, r_done_cyc, r_acc, r_rd;
    logic [31:0] r_rd_w [4];
    logic r_busy_post, r_busy_abort;

    ccff_chain_loader_if #(.WORD_W(32)) bus ();

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(40)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .start      (start),
        .abort      (abort),
        .host       (bus),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters at bit 39, bit 0 is the tail.
    always @(posedge prog_clk) begin
        if (chain_load) chain <= chain_preset;
        else if (shift_en) chain <= {ccff_head, chain[39:1]};
    end
    assign ccff_tail = chain[0];

    task automatic preset_chain(input logic [39:0] v);
        @(posedge prog_clk); #1;
        chain_preset = v; chain_load = 1'b1;
        @(posedge prog_clk); #1;
        chain_load = 1'b0;
    endtask

    // One load run; cycle 0 is the start cycle. Negative arguments disable a feature.
    task automatic run_load(input int w1_avail, input int rd_lo_from, input int rd_lo_to,
                            input int abort_at, input int extra_start_at);
        int widx;
        widx = 0; r_shift = 0; r_first = -1; r_last = -1; r_done = 0; r_done_cyc = -1;
        r_rd = 0; r_busy_post = 1'bx; r_busy_abort = 1'bx;
        for (int c = 0; c < 150; c++) begin
            @(posedge prog_clk); #1;
            start    = (c == 0) || (c == extra_start_at);
            abort    = (c == abort_at);
            bus.wr_data  = (widx == 0) ? W0 : ((widx == 1) ? W1 : W2);
            bus.wr_valid = (widx < 3) && (c >= ((widx == 0) ? 0 : w1_avail));
            bus.rd_ready = !((c >= rd_lo_from) && (c < rd_lo_to));
            @(negedge prog_clk);
            if (shift_en) begin
                r_shift++;
                if (r_first < 0) r_first = c;
                r_last = c;
            end
            if (done) begin r_done++; r_done_cyc = c; end
            if (bus.wr_valid && bus.wr_ready) widx++;
            if (bus.rd_valid && bus.rd_ready && r_rd < 4) begin r_rd_w[r_rd] = bus.rd_data; r_rd++; end
            if (abort_at >= 0 && c == abort_at + 1) r_busy_abort = busy;
            if (r_done_cyc >= 0 && c == r_done_cyc + 1) begin r_busy_post = busy; break; end
            if (abort_at >= 0 && c == abort_at + 3) break;
        end
        r_acc = widx;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        n_checks++; if ({busy, shift_en, ccff_head, bus.wr_ready, bus.rd_valid, done} !== 6'b0) begin
            n_fail++; $display("FAIL por_outputs got %b want 000000", {busy, shift_en, ccff_head, bus.wr_ready, bus.rd_valid, done}); end
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL por_rd_data got %h want 0", bus.rd_data); end
        @(posedge prog_clk); #1; prog_rst_n = 1'b1;
        @(posedge prog_clk); #1; start = 1'b1; bus.wr_data = W0; bus.wr_valid = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0;
        repeat (9) @(posedge prog_clk);
        #1;
        n_checks++; if ({busy, shift_en} !== 2'b11) begin n_fail++; $display("FAIL midload_active got %b want 11", {busy, shift_en}); end
        #1; prog_rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, shift_en, ccff_head, bus.wr_ready, bus.rd_valid, done} !== 6'b0) begin
            n_fail++; $display("FAIL midload_reset got %b want 000000", {busy, shift_en, ccff_head, bus.wr_ready, bus.rd_valid, done}); end
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL midload_rd_data got %h want 0", bus.rd_data); end
        @(posedge prog_clk); #1; prog_rst_n = 1'b1; bus.wr_valid = 1'b0;
        @(negedge prog_clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle got %b want 0", busy); end
    endtask

    task automatic test_full_load;
        preset_chain(40'hA5A5A5A5A5);
        run_load(0, -1, -1, -1, -1);
        n_checks++; if (r_shift !== 40) begin n_fail++; $display("FAIL full_shifts got %0d want 40", r_shift); end
        n_checks++; if (r_first !== 2 || r_last !== 41) begin n_fail++; $display("FAIL full_window got %0d..%0d want 2..41", r_first, r_last); end
        n_checks++; if (chain !== 40'hCD12345678) begin n_fail++; $display("FAIL full_chain got %h want cd12345678", chain); end
        n_checks++; if (r_rd !== 2 || r_rd_w[0] !== 32'hA5A5A5A5 || r_rd_w[1] !== 32'h000000A5) begin
            n_fail++; $display("FAIL full_readback got %0d words %h %h want 2 words a5a5a5a5 000000a5", r_rd, r_rd_w[0], r_rd_w[1]); end
        n_checks++; if (r_done !== 1 || r_done_cyc !== 43) begin n_fail++; $display("FAIL full_done got %0d at %0d want 1 at 43", r_done, r_done_cyc); end
        n_checks++; if (r_acc !== 2) begin n_fail++; $display("FAIL full_words_accepted got %0d want 2", r_acc); end
        n_checks++; if (r_busy_post !== 1'b0) begin n_fail++; $display("FAIL full_idle_after_done got %b want 0", r_busy_post); end
    endtask

    task automatic test_underflow;
        preset_chain(40'hA5A5A5A5A5);
        run_load(39, -1, -1, -1, -1);
        n_checks++; if (r_shift !== 40) begin n_fail++; $display("FAIL uflow_shifts got %0d want 40", r_shift); end
        n_checks++; if (r_last - r_first + 1 - r_shift !== 6) begin
            n_fail++; $display("FAIL uflow_stall_cycles got %0d want 6", r_last - r_first + 1 - r_shift); end
        n_checks++; if (chain !== 40'hCD12345678) begin n_fail++; $display("FAIL uflow_chain got %h want cd12345678", chain); end
        n_checks++; if (r_done_cyc !== 49) begin n_fail++; $display("FAIL uflow_done_cycle got %0d want 49", r_done_cyc); end
    endtask

    task automatic test_backpressure;
        preset_chain(40'hA5A5A5A5A5);
        run_load(0, 34, 44, -1, -1);
        n_checks++; if (r_shift !== 40) begin n_fail++; $display("FAIL bp_shifts got %0d want 40", r_shift); end
        n_checks++; if (r_last !== 44 || r_last - r_first + 1 - r_shift !== 3) begin
            n_fail++; $display("FAIL bp_stall got last %0d stalls %0d want 44 3", r_last, r_last - r_first + 1 - r_shift); end
        n_checks++; if (r_rd !== 2 || r_rd_w[0] !== 32'hA5A5A5A5 || r_rd_w[1] !== 32'h000000A5) begin
            n_fail++; $display("FAIL bp_readback got %0d words %h %h want 2 words a5a5a5a5 000000a5", r_rd, r_rd_w[0], r_rd_w[1]); end
        n_checks++; if (chain !== 40'hCD12345678) begin n_fail++; $display("FAIL bp_chain got %h want cd12345678", chain); end
        n_checks++; if (r_done_cyc !== 46) begin n_fail++; $display("FAIL bp_done_cycle got %0d want 46", r_done_cyc); end
    endtask

    task automatic test_abort;
        preset_chain(40'hCD12345678);
        run_load(0, -1, -1, 19, -1);
        n_checks++; if (r_shift !== 17) begin n_fail++; $display("FAIL abort_shifts got %0d want 17", r_shift); end
        n_checks++; if (r_busy_abort !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", r_busy_abort); end
        n_checks++; if (r_done !== 0 || r_rd !== 0) begin n_fail++; $display("FAIL abort_no_done got done %0d rd %0d want 0 0", r_done, r_rd); end
        n_checks++; if (chain !== 40'h2B3C66891A) begin n_fail++; $display("FAIL abort_chain got %h want 2b3c66891a", chain); end
        run_load(0, -1, -1, -1, -1);
        n_checks++; if (r_rd !== 2 || r_rd_w[0] !== 32'h3C66891A || r_rd_w[1] !== 32'h0000002B) begin
            n_fail++; $display("FAIL reload_readback got %0d words %h %h want 2 words 3c66891a 0000002b", r_rd, r_rd_w[0], r_rd_w[1]); end
        n_checks++; if (chain !== 40'hCD12345678 || r_done_cyc !== 43) begin
            n_fail++; $display("FAIL reload_chain got %h done %0d want cd12345678 43", chain, r_done_cyc); end
    endtask

    task automatic test_start_ignored;
        preset_chain(40'hA5A5A5A5A5);
        run_load(0, -1, -1, -1, 20);
        n_checks++; if (r_shift !== 40 || r_done !== 1 || r_done_cyc !== 43) begin
            n_fail++; $display("FAIL busy_start got shifts %0d done %0d at %0d want 40 1 43", r_shift, r_done, r_done_cyc); end
        n_checks++; if (chain !== 40'hCD12345678) begin n_fail++; $display("FAIL busy_start_chain got %h want cd12345678", chain); end
        @(posedge prog_clk); #1; start = 1'b1; abort = 1'b1; bus.wr_data = W0; bus.wr_valid = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        n_checks++; if ({busy, bus.wr_ready, shift_en} !== 3'b000) begin
            n_fail++; $display("FAIL start_abort got %b want 000", {busy, bus.wr_ready, shift_en}); end
        @(negedge prog_clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_late got %b want 0", busy); end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        prog_rst_n = 1'b0; start = 1'b0; abort = 1'b0; chain_load = 1'b0;
        chain_preset = 40'h0; bus.wr_data = 32'h0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
        test_reset();
        test_full_load();
        test_underflow();
        test_backpressure();
        test_abort();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
